shared_mem_arbiter: RTL
=======================

# shared_mem_arbiter

Single-port arbiter between the PCI host and `user_interface` for the shared 32-bit on-chip memory, plus the 32-bit handshake flag register. Host accesses are posted into a small in-order FIFO. FPGA accesses normally take priority, and the FIFO drains when the port is free. The block supplies `rd_data`, `rd_ready` and `in_flag` to `user_interface`, and consumes that block's `rd_req`, `FPGA_wr_en`, `req_addr`, `write_data`, `flag_we` and `out_flag`.

## Interface
- `PCI_FIFO_DEPTH`, 4: host request FIFO entries (power of 2, ≥2).
- `FLAG_ADDR`, 21'h07FFFE: word address that maps to the flag register.
- One clock; reset is synchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `pci_wr_en` in 1: host write request.
- `pci_rd_en` in 1: host read request; mutually exclusive with `pci_wr_en`.
- `pci_req_addr` in 21: host word address.
- `pci_input_data` in 32: host write data.
- `pci_full` out 1: FIFO full; host must hold off.
- `pci_rd_data` out 32: host read data.
- `pci_rd_valid` out 1: one-cycle pulse qualifying `pci_rd_data`.
- `pci_overflow` out 1: sticky; a host request arrived while `pci_full`.
- `rd_req` in 1: FPGA read request, single-cycle pulse.
- `FPGA_wr_en` in 1: FPGA write request, single-cycle pulse.
- `req_addr` in 21: FPGA word address.
- `write_data` in 32: FPGA write data.
- `flag_we` in 1: FPGA flag write.
- `out_flag` in 32: FPGA flag value.
- `rd_data` out 32: FPGA read data.
- `rd_ready` out 1: one-cycle pulse qualifying `rd_data`.
- `in_flag` out 32: current flag register value.
- `flag_collision` out 1: sticky; a host flag write was lost to a same-cycle FPGA `flag_we`.
- `mem_addr` out 21: SRAM address.
- `mem_wdata` out 32: SRAM write data.
- `mem_we` out 1: SRAM write enable.
- `mem_re` out 1: SRAM read enable.
- `mem_rdata` in 32: SRAM read data, valid the cycle after `mem_re`.

## Operation
- **FIFO push.** A host request is pushed when `(pci_wr_en|pci_rd_en) && !pci_full`. The entry holds {op, addr, data}. A request that arrives while full is dropped and sets `pci_overflow`.
- **Grant order, one memory access per cycle:**
  1. Pending FPGA skid entry.
  2. New FPGA request, unless the FIFO is full.
  3. FIFO head.
- **Full-FIFO case.** If the FIFO is full and a new FPGA request arrives, the FIFO head is granted. The FPGA request is captured in a one-entry skid register and issues next cycle, so FPGA latency is at most +1 cycle.
- **Flag address.** An access to `FLAG_ADDR` never touches the SRAM, and `mem_re`/`mem_we` stay low.
  - Read: data comes from the flag register, with the same latency as an SRAM read.
  - Write: updates the flag register.
- **Flag ordering.** Host flag writes travel through the FIFO. The flag therefore changes only after every earlier host data write has committed.
- **Flag write priority.** `flag_we` writes `out_flag` directly and needs no memory grant. If a host flag write drains in the same cycle, the FPGA value wins and `flag_collision` is set.
- **Read return routing.** A registered tag (none / fpga / host) records who issued the read. The next cycle asserts either `rd_ready` or `pci_rd_valid`, and the data comes from `mem_rdata` or the registered flag value.
- **Idle memory outputs.** With no grant, `mem_we`/`mem_re` are 0. `mem_addr`/`mem_wdata` hold their last values.

## Timing
- **Reset values.** FIFO empty; skid empty; flag register 0; all pulses 0; `pci_full` 0; sticky bits 0; `mem_*` 0.
- **Reset mid-operation.** In-flight reads are discarded and no `rd_ready` follows.
- **Memory drive.** `mem_*` are driven combinationally from the grant in the request cycle.
- **FPGA read latency.** `rd_ready` is asserted exactly 1 cycle after the request, or 2 cycles if skidded.
- **Host read latency.** ≥2 cycles after push: push at N, earliest issue at N+1, `pci_rd_valid` at N+2.
- **`pci_full`.** Derived from the registered count. A push and a pop in the same cycle at full is not allowed: the push is dropped.
- **Count arithmetic.** Count width is $clog_2(DEPTH)+1$. Read and write pointers wrap modulo DEPTH.
- **`in_flag` timing.** `in_flag` updates the cycle after the flag write.
- **Illegal FPGA input.** `rd_req` and `FPGA_wr_en` together is illegal; the assertion fires and the write wins.

## Structure
- Package `shared_mem_pkg`:
  - `ADDR_W`=21, `DATA_W`=32, `FLAG_ADDR`.
  - Flag codes `FLAG_START`=32'h0001_0000, `FLAG_ACK`=32'h2, `FLAG_DONE`=32'h4.
  - `mem_op_e` {RD, WR}.
  - `mem_req_t` struct {op, addr, data}.
  - `rd_tag_e` {NONE, FPGA, HOST}.
- Sub-module `pci_req_fifo`: parameterised synchronous FIFO of `mem_req_t`, exposing full, empty and count.

## Test plan
- **Host fill, then start.** Host writes 0xA5A5_0001 to 0x100, then 32'h0001_0000 to `FLAG_ADDR`, with the FPGA idle → SRAM gets 0x100 first, and `in_flag`=0x0001_0000 one cycle after the second drain.
- **FPGA read.** `rd_req` at 0x200, where SRAM holds 0xDEAD_BEEF → `mem_re` in the same cycle; `rd_ready`=1 with `rd_data`=0xDEAD_BEEF next cycle.
- **Contention at full.** Fill the FIFO with 4 host writes while FPGA writes hold the port; then pulse FPGA `rd_req` → head drains, skid holds the read, `rd_ready` arrives 2 cycles after the request, and nothing is lost.
- **Overflow.** A fifth host write while `pci_full` → `pci_overflow`=1 and the entry is absent from SRAM.
- **Flag collision.** A host flag write (0x1) drains in the same cycle as `flag_we` with 0x4 → `in_flag`=0x4 and `flag_collision`=1.
- **Reset mid-read.** `rd_req`, then `rst_n`=0 the next cycle → no `rd_ready`, `in_flag`=0, FIFO empty.

Source files
------------

// File: rtl/shared_mem_pkg.sv
// Shared types and constants for the host/FPGA shared-memory arbiter.
package shared_mem_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] FLAG_ADDR = 21'h07FFFE;

    // Handshake codes exchanged through the flag register
    localparam logic [DATA_W-1:0] FLAG_START = 32'h0001_0000;
    localparam logic [DATA_W-1:0] FLAG_ACK   = 32'h0000_0002;
    localparam logic [DATA_W-1:0] FLAG_DONE  = 32'h0000_0004;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e             op;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } mem_req_t;

    // Who is waiting on the read data returning next cycle
    typedef enum logic [1:0] {
        NONE = 2'd0,
        FPGA = 2'd1,
        HOST = 2'd2
    } rd_tag_e;

endpackage

// File: rtl/pci_req_fifo.sv
// In-order request FIFO for posted host accesses; DEPTH must be a power of 2.
module pci_req_fifo
    import shared_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  mem_req_t         wr_req,
    input  logic             pop,
    output mem_req_t         head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    mem_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; a push at full is refused even if a pop happens
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_req;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Single-port arbiter for the shared SRAM and handshake flag register.
// FPGA requests win the port unless the host FIFO is full, in which case the
// FIFO head drains and the FPGA request waits one cycle in a skid register.
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int                PCI_FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] FLAG_ADDR      = shared_mem_pkg::FLAG_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    // host side
    input  logic              pci_wr_en,
    input  logic              pci_rd_en,
    input  logic [ADDR_W-1:0] pci_req_addr,
    input  logic [DATA_W-1:0] pci_input_data,
    output logic              pci_full,
    output logic [DATA_W-1:0] pci_rd_data,
    output logic              pci_rd_valid,
    output logic              pci_overflow,
    // user_interface side
    input  logic              rd_req,
    input  logic              FPGA_wr_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] out_flag,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ready,
    output logic [DATA_W-1:0] in_flag,
    output logic              flag_collision,
    // SRAM port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(PCI_FIFO_DEPTH) + 1;

    mem_req_t          host_req;
    mem_req_t          fpga_req;
    mem_req_t          fifo_head;
    mem_req_t          grant_req;
    mem_req_t          skid_q, skid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              host_valid, fpga_valid;
    logic              grant_valid, grant_host, grant_flag;
    logic [DATA_W-1:0] flag_q, flag_d;
    logic [DATA_W-1:0] flag_snap_q;
    logic              flag_rd_q, flag_rd_d;
    rd_tag_e           tag_q, tag_d;
    logic              overflow_q, overflow_d;
    logic              collision_q, collision_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Nothing is accepted while reset is held, so no access escapes during reset
    always_comb begin
        host_valid = rst_n && (pci_wr_en || pci_rd_en);
        fpga_valid = rst_n && (rd_req || FPGA_wr_en);
        host_req   = '{op: (pci_wr_en ? WR : RD), addr: pci_req_addr, data: pci_input_data};
        fpga_req   = '{op: (FPGA_wr_en ? WR : RD), addr: req_addr, data: write_data};
        fifo_push  = host_valid && !pci_full;
    end

    pci_req_fifo #(
        .DEPTH (PCI_FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .wr_req (host_req),
        .pop    (fifo_pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign pci_full = (fifo_count == CNT_W'(PCI_FIFO_DEPTH));

    // Grant: skid entry, then new FPGA request (unless FIFO full), then FIFO head
    always_comb begin
        grant_valid  = 1'b0;
        grant_host   = 1'b0;
        grant_req    = fpga_req;
        fifo_pop     = 1'b0;
        skid_valid_d = 1'b0;
        skid_d       = skid_q;
        if (!rst_n) begin
            grant_valid = 1'b0;
        end else if (skid_valid_q) begin
            grant_valid = 1'b1;
            grant_req   = skid_q;
            if (fpga_valid) begin
                skid_valid_d = 1'b1;
                skid_d       = fpga_req;
            end
        end else if (fpga_valid && !fifo_full) begin
            grant_valid = 1'b1;
        end else begin
            if (!fifo_empty) begin
                grant_valid = 1'b1;
                grant_host  = 1'b1;
                grant_req   = fifo_head;
                fifo_pop    = 1'b1;
            end
            if (fpga_valid) begin
                skid_valid_d = 1'b1;
                skid_d       = fpga_req;
            end
        end
    end

    // SRAM drive: flag-address accesses stay off the SRAM; idle port holds addr/data
    always_comb begin
        grant_flag = grant_valid && (grant_req.addr == FLAG_ADDR);
        mem_we     = grant_valid && !grant_flag && (grant_req.op == WR);
        mem_re     = grant_valid && !grant_flag && (grant_req.op == RD);
        mem_addr   = (mem_we || mem_re) ? grant_req.addr : mem_addr_q;
        mem_wdata  = mem_we ? grant_req.data : mem_wdata_q;
    end

    // Flag updates, read tagging and sticky error bits
    always_comb begin
        flag_d      = flag_q;
        collision_d = collision_q;
        if (grant_flag && (grant_req.op == WR)) begin
            flag_d = grant_req.data;
        end
        if (flag_we && rst_n) begin
            flag_d = out_flag;
            if (grant_flag && grant_host && (grant_req.op == WR)) begin
                collision_d = 1'b1;
            end
        end
        tag_d     = NONE;
        flag_rd_d = 1'b0;
        if (grant_valid && (grant_req.op == RD)) begin
            tag_d     = grant_host ? HOST : FPGA;
            flag_rd_d = grant_flag;
        end
        overflow_d = overflow_q || (host_valid && pci_full);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            flag_q       <= '0;
            flag_snap_q  <= '0;
            flag_rd_q    <= 1'b0;
            tag_q        <= NONE;
            overflow_q   <= 1'b0;
            collision_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            flag_q       <= flag_d;
            flag_snap_q  <= flag_q;
            flag_rd_q    <= flag_rd_d;
            tag_q        <= tag_d;
            overflow_q   <= overflow_d;
            collision_q  <= collision_d;
            mem_addr_q   <= mem_addr;
            mem_wdata_q  <= mem_wdata;
        end
    end

    // Read return; gating with rst_n drops a read that was in flight when reset hit
    always_comb begin
        rd_ready       = rst_n && (tag_q == FPGA);
        pci_rd_valid   = rst_n && (tag_q == HOST);
        rd_data        = flag_rd_q ? flag_snap_q : mem_rdata;
        pci_rd_data    = flag_rd_q ? flag_snap_q : mem_rdata;
        in_flag        = flag_q;
        pci_overflow   = overflow_q;
        flag_collision = collision_q;
    end

    // user_interface must never pulse read and write together (write is served)
    assert property (@(posedge clk) disable iff (!rst_n) !(rd_req && FPGA_wr_en));

endmodule
